// File: rtl/spi_gain_writer_if.sv
// SPI pin bundle plus the register-map write port and status of spi_gain_writer.
// The host side drives the SPI pins; the decoder drives the map write port.
interface spi_gain_writer_if;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       we;
  logic [7:0] addr;
  logic [7:0] data;
  logic       frame_err;
  logic       addr_err;
  logic [7:0] wr_count;

  modport master (
    output sclk, cs_n, mosi,
    input  we, addr, data, frame_err, addr_err, wr_count
  );

  modport slave (
    input  sclk, cs_n, mosi,
    output we, addr, data, frame_err, addr_err, wr_count
  );
endinterface

// File: rtl/spi_gain_writer.sv
// SPI slave decoder turning 16-bit address/gain frames into register-map writes.
// SPI pins are synchronised into clk; all logic runs on clk.
//
// state   | meaning
// IDLE    | between frames, waiting for cs_n low
// ADDR    | shifting the address byte
// DATA    | shifting the gain byte
// COMMIT  | one cycle: write strobe or address error
// WAIT_CS | frame finished or discarded, waiting for cs_n high
module spi_gain_writer #(
  parameter int NUM_REGS    = 10,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  spi_gain_writer_if.slave bus
);

  localparam int SW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, COMMIT, WAIT_CS} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q;
  logic [15:0]            sh_q, sh_d;
  logic [4:0]             bitcnt_q, bitcnt_d;
  logic [SW-1:0]          settle_q;
  logic [7:0]             addr_q, addr_d, data_q, data_d, wr_cnt_q, wr_cnt_d;
  logic                   sclk_s, cs_s, mosi_s, sclk_rise;
  logic                   commit, addr_ok, we;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_prev_q <= sclk_s;
    end
  end

  // settle_q masks the synchroniser's reset value of cs_n so a frame still
  // in progress across reset is not mistaken for a fresh cs_n rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= WAIT_CS;
      sh_q     <= '0;
      bitcnt_q <= '0;
      settle_q <= SW'(SYNC_STAGES);
      addr_q   <= '0;
      data_q   <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      bitcnt_q <= bitcnt_d;
      if (settle_q != '0) settle_q <= settle_q - SW'(1);
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    bitcnt_d = bitcnt_q;
    case (state_q)
      IDLE: begin
        bitcnt_d = '0;
        if (!cs_s) state_d = ADDR;
      end
      ADDR, DATA: begin
        // cs_n high beats a coincident sclk rise
        if (cs_s) begin
          state_d = IDLE;
        end else if (sclk_rise) begin
          sh_d     = {sh_q[14:0], mosi_s};
          bitcnt_d = bitcnt_q + 5'd1;
          if (state_q == ADDR && bitcnt_q == 5'd7)  state_d = DATA;
          if (state_q == DATA && bitcnt_q == 5'd15) state_d = COMMIT;
        end
      end
      COMMIT:  state_d = WAIT_CS;
      WAIT_CS: if (cs_s && settle_q == '0) state_d = IDLE;
      default: state_d = WAIT_CS;
    endcase
  end

  always_comb begin
    commit   = (state_q == COMMIT);
    addr_ok  = ({1'b0, sh_q[15:8]} < 9'(NUM_REGS));
    we       = commit & addr_ok;
    addr_d   = we ? sh_q[15:8] : addr_q;
    data_d   = we ? sh_q[7:0]  : data_q;
    wr_cnt_d = we ? wr_cnt_q + 8'd1 : wr_cnt_q;
  end

  assign bus.we        = we;
  assign bus.addr      = addr_d;
  assign bus.data      = data_d;
  assign bus.addr_err  = commit & ~addr_ok;
  assign bus.frame_err = (state_q == ADDR || state_q == DATA) & cs_s;
  assign bus.wr_count  = wr_cnt_q;

endmodule
